// File: rtl/fetch_unit.sv
// fetch_unit: 6502 fetch stage. Owns the PC, reads opcode and operand bytes over a
// req/ack port, strobes them into IR/operand registers, and offers the instruction downstream.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0200)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        opc_len,
  output logic [DATA_W-1:0] byte_out,
  output logic              ir_load,
  output logic              op_lo_load,
  output logic              op_hi_load,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              busy
);
  typedef enum logic [1:0] {F_OP, F_LO, F_HI, HOLD} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] byte_q;
  logic [1:0]        len_q, len_d;
  logic              mem_rd_q, ir_q, lo_q, hi_q, valid_q, last;
  assign len_d = (opc_len == 2'd0) ? 2'd1 : opc_len;
  // Final byte of the instruction: the opcode length decides on F_OP, the held length afterwards.
  assign last = state_q == F_HI || (state_q == F_LO && len_q == 2'd2) ||
                (state_q == F_OP && len_d == 2'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= F_OP;
      pc_q     <= RESET_PC;
      mem_rd_q <= 1'b0;
      byte_q   <= '0;
      len_q    <= 2'd1;
      ir_q     <= 1'b0;
      lo_q     <= 1'b0;
      hi_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      ir_q <= 1'b0;
      lo_q <= 1'b0;
      hi_q <= 1'b0;
      if (pc_load) begin
        pc_q     <= pc_in;
        state_q  <= F_OP;
        mem_rd_q <= 1'b0;
        valid_q  <= 1'b0;
      end else if (state_q == HOLD) begin
        if (instr_ready) begin
          state_q  <= F_OP;
          valid_q  <= 1'b0;
          mem_rd_q <= 1'b1;
        end
      end else if (mem_rd_q && mem_ack) begin
        byte_q   <= mem_data;
        pc_q     <= pc_q + 1'b1;
        ir_q     <= state_q == F_OP;
        lo_q     <= state_q == F_LO;
        hi_q     <= state_q == F_HI;
        len_q    <= (state_q == F_OP) ? len_d : len_q;
        state_q  <= last ? HOLD : (state_q == F_OP ? F_LO : F_HI);
        valid_q  <= last;
        mem_rd_q <= !last;
      end else begin
        mem_rd_q <= 1'b1;
      end
    end
  end
  assign mem_addr    = pc_q;
  assign mem_rd      = mem_rd_q;
  assign byte_out    = byte_q;
  assign ir_load     = ir_q;
  assign op_lo_load  = lo_q;
  assign op_hi_load  = hi_q;
  assign instr_valid = valid_q;
  assign busy        = state_q != HOLD;
endmodule
